// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg: shared register map, CTRL field layout, reset constants and
// the byte-lane merge helper used by the memory-mapped machine timer.
package mmio_timer_pkg;

  // Byte offsets inside the 32-byte register window
  localparam logic [4:0] OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] OFF_CTRL        = 5'h10;
  localparam logic [4:0] OFF_STATUS      = 5'h14;

  // CTRL register bit positions
  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_IE        = 1;
  localparam int unsigned CTRL_PRESC_LSB = 8;
  localparam int unsigned CTRL_PRESC_MSB = 15;

  typedef struct packed {
    logic [7:0] presc;
    logic       ie;
    logic       en;
  } timer_ctrl_t;

  localparam logic [63:0] MTIMECMP_RST = '1;

  // Replace the bytes of cur selected by mask with the matching bytes of wdata
  function automatic logic [31:0] apply_mask(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  mask);
    logic [31:0] r;
    r = cur;
    for (int unsigned k = 0; k < 4; k++) begin
      if (mask[k]) r[8*k +: 8] = wdata[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_timer_tick_gen.sv
// tick_gen: prescaler for the machine timer.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   en        - counting enable; counter held at 0 while low
//   clr       - synchronous clear (CTRL written)
//   presc     - terminal count; a tick every presc+1 enabled cycles
//   tick      - one-cycle pulse, mtime advances on the edge ending it
module tick_gen
  import mmio_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] presc,
  output logic       tick
);

  logic [7:0] pcnt;

  // A tick depends only on the current count, so a CTRL write in a terminal
  // cycle still produces that cycle's tick before the counter restarts.
  assign tick = en && (pcnt == presc);

  always_ff @(posedge clk) begin
    if (rst || !en || clr) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 8'd1;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped machine timer responder on the data-memory bus.
// Holds a 64-bit free-running mtime, a 64-bit mtimecmp, CTRL (EN/IE/PRESC)
// and a sticky PEND flag; irq_o = PEND & IE.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   mem_addr_i    - byte address; 32-byte window at BASE_ADDR
//   we_i, re_i    - write / read strobes, qualified by window hit
//   mem_W_data_i  - write data
//   mem_W_mask_i  - byte enables (bit k -> byte k)
//   mem_R_data_o  - combinational read data, 0 when not reading the window
//   irq_o         - level timer interrupt
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [31:0] mem_W_data_i,
  input  logic [3:0]  mem_W_mask_i,
  output logic [31:0] mem_R_data_o,
  output logic        irq_o
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  timer_ctrl_t ctrl;
  logic        pend;

  logic        hit;
  logic [4:0]  off;
  logic        wr_en;
  logic        rd_en;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        wr_ctrl;
  logic        w1c_pend;
  logic        match;
  logic        tick;
  logic [31:0] ctrl_word;

  // Address decode; the two low address bits are masked off here
  assign hit   = (mem_addr_i & ~32'h1F) == BASE_ADDR;
  assign off   = mem_addr_i[4:0] & 5'h1C;
  assign wr_en = hit && we_i && (mem_W_mask_i != 4'b0000);
  assign rd_en = hit && re_i;

  assign wr_mtime_lo = wr_en && (off == OFF_MTIME_LO);
  assign wr_mtime_hi = wr_en && (off == OFF_MTIME_HI);
  assign wr_cmp_lo   = wr_en && (off == OFF_MTIMECMP_LO);
  assign wr_cmp_hi   = wr_en && (off == OFF_MTIMECMP_HI);
  assign wr_ctrl     = wr_en && (off == OFF_CTRL);
  assign w1c_pend    = wr_en && (off == OFF_STATUS) && mem_W_mask_i[0] && mem_W_data_i[0];

  // Compare uses the flop values, so a same-cycle mtimecmp write cannot
  // affect this cycle's PEND update.
  assign match = mtime >= mtimecmp;

  assign ctrl_word = {16'h0000, ctrl.presc, 6'b000000, ctrl.ie, ctrl.en};

  tick_gen u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (ctrl.en),
    .clr   (wr_ctrl),
    .presc (ctrl.presc),
    .tick  (tick)
  );

  // Any write into either mtime half blocks the increment for the whole
  // 64-bit counter that cycle, so a partial write never sees a carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= '0;
    end else if (wr_mtime_lo || wr_mtime_hi) begin
      if (wr_mtime_lo) mtime[31:0]  <= apply_mask(mtime[31:0],  mem_W_data_i, mem_W_mask_i);
      if (wr_mtime_hi) mtime[63:32] <= apply_mask(mtime[63:32], mem_W_data_i, mem_W_mask_i);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp <= MTIMECMP_RST;
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= apply_mask(mtimecmp[31:0],  mem_W_data_i, mem_W_mask_i);
      if (wr_cmp_hi) mtimecmp[63:32] <= apply_mask(mtimecmp[63:32], mem_W_data_i, mem_W_mask_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= '0;
    end else if (wr_ctrl) begin
      if (mem_W_mask_i[0]) begin
        ctrl.en <= mem_W_data_i[CTRL_EN];
        ctrl.ie <= mem_W_data_i[CTRL_IE];
      end
      if (mem_W_mask_i[1]) ctrl.presc <= mem_W_data_i[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
    end
  end

  // Set has priority over write-1-to-clear
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (match) begin
      pend <= 1'b1;
    end else if (w1c_pend) begin
      pend <= 1'b0;
    end
  end

  assign irq_o = pend & ctrl.ie;

  always_comb begin
    mem_R_data_o = '0;
    if (rd_en) begin
      case (off)
        OFF_MTIME_LO:    mem_R_data_o = mtime[31:0];
        OFF_MTIME_HI:    mem_R_data_o = mtime[63:32];
        OFF_MTIMECMP_LO: mem_R_data_o = mtimecmp[31:0];
        OFF_MTIMECMP_HI: mem_R_data_o = mtimecmp[63:32];
        OFF_CTRL:        mem_R_data_o = ctrl_word;
        OFF_STATUS:      mem_R_data_o = {31'h0, pend};
        default:         mem_R_data_o = '0;
      endcase
    end
  end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped machine timer that answers on the core's data-memory bus as a responder alongside `d_mem`. It holds a 64-bit free-running `mtime`, a 64-bit `mtimecmp`, a prescaler and a sticky match flag, and raises `irq_o` when the enabled compare hits. Port naming and read/write semantics match `d_mem`, so `top` can decode the window and mux `mem_R_data_o` with no glue logic.

## Interface
- `BASE_ADDR`, default 32'h0000_0400: byte address of the 32-byte register window; must be 32-byte aligned.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `mem_addr_i`  in  32  byte address from the core.
- `we_i`  in  1  write strobe, qualified by address hit.
- `re_i`  in  1  read strobe, qualified by address hit.
- `mem_W_data_i`  in  32  write data.
- `mem_W_mask_i`  in  4  byte enables; bit k writes byte k (bits [8k+7:8k]).
- `mem_R_data_o`  out  32  read data.
- `irq_o`  out  1  timer interrupt request, level.

## Operation
- Hit: `(mem_addr_i & ~32'h1F) == BASE_ADDR`. `mem_addr_i[1:0]` ignored. No hit: no state change, `mem_R_data_o` = 0.
- Register offsets:
  - 0x00 MTIME_LO (RW)
  - 0x04 MTIME_HI (RW)
  - 0x08 MTIMECMP_LO (RW)
  - 0x0C MTIMECMP_HI (RW)
  - 0x10 CTRL (RW): bit0 EN, bit1 IE, bits[15:8] PRESC; other bits read 0.
  - 0x14 STATUS: bit0 PEND, write-1-to-clear; other bits read 0.
  - 0x18, 0x1C: read 0, writes ignored.
- Writes are byte-masked; unmasked bytes hold their value. A write with mask 4'b0000 is a no-op.
- Prescaler: 8-bit counter `pcnt`. When EN=1:
  - `pcnt == PRESC` generates a tick and resets `pcnt` to 0; otherwise `pcnt` increments.
  - PRESC = 0 gives a tick every cycle.
- `pcnt` is cleared when EN = 0 or on any write hitting CTRL.
- On a tick, `mtime` increments as a full 64-bit value with carry from LO into HI; 2^64−1 wraps to 0.
- Match: every cycle, the flop values are compared unsigned, `mtime >= mtimecmp`; a true result sets PEND on the next edge.
- PEND is sticky and is cleared by writing 1 to STATUS bit0 with mask bit0 set.
- `irq_o` = PEND & IE, a combinational AND of two flops.
- Simultaneous events:
  - Write to any byte of MTIME_LO/HI in a tick cycle: the increment is suppressed for the whole 64-bit counter that cycle; written bytes take the new data, other bytes hold.
  - W1C of PEND in the same cycle the match is true: set wins, PEND stays 1.
  - Write to MTIMECMP in a cycle with a true match: PEND is set from the pre-write compare.
- Read data is combinational from current register state when hit & `re_i`, otherwise 0. `we_i` and `re_i` together: read returns the pre-write value, and the write commits at the edge.

## Timing
- Reset values: `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, CTRL = 0, PEND = 0, `pcnt` = 0.
- Output values in reset: `irq_o` = 0; `mem_R_data_o` = 0 unless a read hits.
- Reset asserted mid-count or mid-write overrides everything in that cycle.
- Write at edge N is visible to a read in cycle N+1 (zero wait states). Read latency is 0 cycles.
- EN set at edge N: first tick at edge N+1+PRESC, so `mtime` reads 1 in cycle N+1+PRESC+1 for PRESC = 0.
- Match true in cycle M: PEND = 1 and `irq_o` = 1 (if IE) from cycle M+1.
- After a W1C at edge N with the match false: `irq_o` low from cycle N+1.

## Structure
- Package `mmio_timer_pkg` holds:
  - offset localparams `OFF_MTIME_LO` … `OFF_STATUS`;
  - CTRL bit positions `CTRL_EN`, `CTRL_IE` and the PRESC field range;
  - packed struct `timer_ctrl_t` {`presc[7:0]`, `ie`, `en`};
  - reset constant `MTIMECMP_RST`.
- One sub-module, `tick_gen`, contains the prescaler counter. Inputs: `clk`, `rst`, `en`, `clr`, `presc[7:0]`. Output: `tick`.
- The remainder is decode, byte-masked register update and read mux in `mmio_timer`.

## Test plan
- Reset, then read all six offsets → MTIME = 0, MTIMECMP = 0xFFFF_FFFF in both halves, CTRL = 0, STATUS = 0; `irq_o` = 0.
- Write CTRL = 0x0000_0001 (PRESC = 0, EN = 1), idle 10 cycles, read MTIME_LO → 10. Then set PRESC = 3 and count 20 cycles → MTIME_LO advances by 5.
- Carry and wrap:
  - Write MTIME_LO = 0xFFFF_FFFF, HI = 0 with EN = 1; after 1 tick → LO = 0, HI = 1.
  - Write both halves to 0xFFFF_FFFF; after 1 tick → both halves 0.
- Byte mask: write 0xAABBCCDD to MTIMECMP_LO with mask 4'b0101 over 0xFFFF_FFFF → reads 0xFFBBFFDD. Write mask 0 → unchanged. Write at offset 0x1C → reads 0.
- Interrupt: MTIMECMP = 5, CTRL = 0x3; PEND and `irq_o` rise exactly one cycle after MTIME reaches 5. W1C while still matching → PEND stays 1. Set MTIMECMP = 100, then W1C → `irq_o` = 0 the next cycle.
- Collisions and reset:
  - Write MTIME_LO = 0x100 in a tick cycle → reads 0x100, not 0x101.
  - Simultaneous `re_i` + `we_i` to CTRL returns the old value.
  - `rst` pulsed while counting → all registers at reset values on the next cycle.
